// File: rtl/id_ex_operand_stage_if.sv
// Bundle of the ID/EX operand stage signals: decode request, forwarding
// sources and the registered ALU-side results.
interface id_ex_operand_stage_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned CTRL_WIDTH  = 3,
    parameter int unsigned STALL_CNT_W = 16
);
    // Decode side
    logic                   valid_in;
    logic                   ready_out;
    logic                   flush_in;
    logic [REG_ADDR_W-1:0]  rs1_addr_in;
    logic [REG_ADDR_W-1:0]  rs2_addr_in;
    logic [REG_ADDR_W-1:0]  rd_addr_in;
    logic [DATA_WIDTH-1:0]  rs1_data_in;
    logic [DATA_WIDTH-1:0]  rs2_data_in;
    logic [DATA_WIDTH-1:0]  imm_in;
    logic [DATA_WIDTH-1:0]  pc_in;
    logic                   ALUsrc_in;
    logic [CTRL_WIDTH-1:0]  ALUctrl_in;
    logic                   regwrite_in;
    // Forwarding sources
    logic                   exmem_we_in;
    logic [REG_ADDR_W-1:0]  exmem_rd_in;
    logic [DATA_WIDTH-1:0]  exmem_data_in;
    logic                   memwb_we_in;
    logic [REG_ADDR_W-1:0]  memwb_rd_in;
    logic [DATA_WIDTH-1:0]  memwb_data_in;
    // EX side
    logic                   valid_out;
    logic                   ready_in;
    logic [DATA_WIDTH-1:0]  ALUop1_out;
    logic [DATA_WIDTH-1:0]  ALUop2_out;
    logic [CTRL_WIDTH-1:0]  ALUctrl_out;
    logic [DATA_WIDTH-1:0]  store_data_out;
    logic [REG_ADDR_W-1:0]  rd_addr_out;
    logic                   regwrite_out;
    logic [DATA_WIDTH-1:0]  pc_out;
    logic [STALL_CNT_W-1:0] stall_cnt_out;

    // The operand stage itself
    modport slave (
        input  valid_in, flush_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
               rs1_data_in, rs2_data_in, imm_in, pc_in, ALUsrc_in, ALUctrl_in,
               regwrite_in, exmem_we_in, exmem_rd_in, exmem_data_in,
               memwb_we_in, memwb_rd_in, memwb_data_in, ready_in,
        output ready_out, valid_out, ALUop1_out, ALUop2_out, ALUctrl_out,
               store_data_out, rd_addr_out, regwrite_out, pc_out, stall_cnt_out
    );

    // Whoever drives decode/forwarding and consumes the EX side
    modport master (
        output valid_in, flush_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
               rs1_data_in, rs2_data_in, imm_in, pc_in, ALUsrc_in, ALUctrl_in,
               regwrite_in, exmem_we_in, exmem_rd_in, exmem_data_in,
               memwb_we_in, memwb_rd_in, memwb_data_in, ready_in,
        input  ready_out, valid_out, ALUop1_out, ALUop2_out, ALUctrl_out,
               store_data_out, rd_addr_out, regwrite_out, pc_out, stall_cnt_out
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. Forwards from EX/MEM and MEM/WB at
// capture time, picks register or immediate for operand 2, and counts cycles
// spent stalled by the EX stage.
module id_ex_operand_stage #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned CTRL_WIDTH  = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    id_ex_operand_stage_if.slave bus
);

    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_op1;
    logic [DATA_WIDTH-1:0]  r_op2;
    logic [CTRL_WIDTH-1:0]  r_ctrl;
    logic [DATA_WIDTH-1:0]  r_store;
    logic [REG_ADDR_W-1:0]  r_rd;
    logic                   r_regwrite;
    logic [DATA_WIDTH-1:0]  r_pc;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic                   w_ready;
    logic                   w_load;
    logic                   w_stalled;
    logic [DATA_WIDTH-1:0]  w_fwd_rs1;
    logic [DATA_WIDTH-1:0]  w_fwd_rs2;

    // x0 reads as zero even if a stale writer claims rd=0; EX/MEM is newer than MEM/WB
    function automatic logic [DATA_WIDTH-1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [DATA_WIDTH-1:0] rf_data,
        input logic                  ex_we,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [DATA_WIDTH-1:0] ex_data,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [DATA_WIDTH-1:0] wb_data
    );
        if (addr == '0) begin
            return '0;
        end else if (ex_we && (ex_rd == addr)) begin
            return ex_data;
        end else if (wb_we && (wb_rd == addr)) begin
            return wb_data;
        end
        return rf_data;
    endfunction

    assign w_ready   = ~r_valid | bus.ready_in;
    assign w_load    = bus.valid_in & w_ready;
    assign w_stalled = r_valid & ~bus.ready_in & ~bus.flush_in;

    // Per-source forwarding mux evaluated on the incoming instruction
    always_comb begin
        w_fwd_rs1 = fwd_sel(bus.rs1_addr_in, bus.rs1_data_in,
                            bus.exmem_we_in, bus.exmem_rd_in, bus.exmem_data_in,
                            bus.memwb_we_in, bus.memwb_rd_in, bus.memwb_data_in);
        w_fwd_rs2 = fwd_sel(bus.rs2_addr_in, bus.rs2_data_in,
                            bus.exmem_we_in, bus.exmem_rd_in, bus.exmem_data_in,
                            bus.memwb_we_in, bus.memwb_rd_in, bus.memwb_data_in);
    end

    // Pipeline register: flush beats load, load beats drain, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_ctrl     <= '0;
            r_store    <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_pc       <= '0;
        end else if (bus.flush_in) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_op1      <= w_fwd_rs1;
            r_op2      <= bus.ALUsrc_in ? bus.imm_in : w_fwd_rs2;
            r_ctrl     <= bus.ALUctrl_in;
            r_store    <= w_fwd_rs2;
            r_rd       <= bus.rd_addr_in;
            r_regwrite <= bus.regwrite_in;
            r_pc       <= bus.pc_in;
        end else if (bus.ready_in) begin
            // Drained with nothing new; payload left stale behind valid=0
            r_valid <= 1'b0;
        end
    end

    // Saturating count of cycles the EX stage held us off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.ready_out      = w_ready;
    assign bus.valid_out      = r_valid;
    assign bus.ALUop1_out     = r_op1;
    assign bus.ALUop2_out     = r_op2;
    assign bus.ALUctrl_out    = r_ctrl;
    assign bus.store_data_out = r_store;
    assign bus.rd_addr_out    = r_rd;
    assign bus.regwrite_out   = r_regwrite & r_valid;
    assign bus.pc_out         = r_pc;
    assign bus.stall_cnt_out  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: a default 16-bit counter instance
// plus a 2-bit counter instance fed the same stimulus to reach saturation.
module tb_id_ex_operand_stage;

    logic clk;
    logic rst_n;

    id_ex_operand_stage_if #(.STALL_CNT_W(16)) bus ();
    id_ex_operand_stage_if #(.STALL_CNT_W(2))  bus_s ();

    id_ex_operand_stage #(.STALL_CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    id_ex_operand_stage #(.STALL_CNT_W(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    // Mirror every input of the main instance onto the narrow-counter instance
    assign bus_s.valid_in      = bus.valid_in;
    assign bus_s.flush_in      = bus.flush_in;
    assign bus_s.rs1_addr_in   = bus.rs1_addr_in;
    assign bus_s.rs2_addr_in   = bus.rs2_addr_in;
    assign bus_s.rd_addr_in    = bus.rd_addr_in;
    assign bus_s.rs1_data_in   = bus.rs1_data_in;
    assign bus_s.rs2_data_in   = bus.rs2_data_in;
    assign bus_s.imm_in        = bus.imm_in;
    assign bus_s.pc_in         = bus.pc_in;
    assign bus_s.ALUsrc_in     = bus.ALUsrc_in;
    assign bus_s.ALUctrl_in    = bus.ALUctrl_in;
    assign bus_s.regwrite_in   = bus.regwrite_in;
    assign bus_s.exmem_we_in   = bus.exmem_we_in;
    assign bus_s.exmem_rd_in   = bus.exmem_rd_in;
    assign bus_s.exmem_data_in = bus.exmem_data_in;
    assign bus_s.memwb_we_in   = bus.memwb_we_in;
    assign bus_s.memwb_rd_in   = bus.memwb_rd_in;
    assign bus_s.memwb_data_in = bus.memwb_data_in;
    assign bus_s.ready_in      = bus.ready_in;

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_in      = 1'b0;
        bus.flush_in      = 1'b0;
        bus.rs1_addr_in   = '0;
        bus.rs2_addr_in   = '0;
        bus.rd_addr_in    = '0;
        bus.rs1_data_in   = '0;
        bus.rs2_data_in   = '0;
        bus.imm_in        = '0;
        bus.pc_in         = '0;
        bus.ALUsrc_in     = 1'b0;
        bus.ALUctrl_in    = '0;
        bus.regwrite_in   = 1'b0;
        bus.exmem_we_in   = 1'b0;
        bus.exmem_rd_in   = '0;
        bus.exmem_data_in = '0;
        bus.memwb_we_in   = 1'b0;
        bus.memwb_rd_in   = '0;
        bus.memwb_data_in = '0;
        bus.ready_in      = 1'b1;
    endtask

    // Scenario 1 stimulus: rs1=5, rs2=7, no forwarding, register operand 2
    task automatic drive_basic();
        idle_inputs();
        bus.valid_in    = 1'b1;
        bus.rs1_addr_in = 5'd1;
        bus.rs1_data_in = 32'd5;
        bus.rs2_addr_in = 5'd2;
        bus.rs2_data_in = 32'd7;
        bus.rd_addr_in  = 5'd4;
        bus.regwrite_in = 1'b1;
        bus.pc_in       = 32'h100;
    endtask

    task automatic check_basic(input string tag);
        check_val({tag, "_valid"}, 64'(bus.valid_out), 64'd1);
        check_val({tag, "_op1"},   64'(bus.ALUop1_out), 64'd5);
        check_val({tag, "_op2"},   64'(bus.ALUop2_out), 64'd7);
        check_val({tag, "_ctrl"},  64'(bus.ALUctrl_out), 64'd0);
        check_val({tag, "_store"}, 64'(bus.store_data_out), 64'd7);
        check_val({tag, "_rd"},    64'(bus.rd_addr_out), 64'd4);
        check_val({tag, "_rw"},    64'(bus.regwrite_out), 64'd1);
        check_val({tag, "_pc"},    64'(bus.pc_out), 64'h100);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        check_val("rst_valid", 64'(bus.valid_out), 64'd0);
        check_val("rst_ready", 64'(bus.ready_out), 64'd1);
        check_val("rst_op1",   64'(bus.ALUop1_out), 64'd0);
        check_val("rst_stall", 64'(bus.stall_cnt_out), 64'd0);
        rst_n = 1'b1;

        // 1: basic load
        drive_basic();
        step();
        check_basic("s1");

        // 2a: EX/MEM wins over MEM/WB on rs1
        idle_inputs();
        bus.valid_in      = 1'b1;
        bus.rs1_addr_in   = 5'd3;
        bus.rs1_data_in   = 32'h99;
        bus.exmem_we_in   = 1'b1;
        bus.exmem_rd_in   = 5'd3;
        bus.exmem_data_in = 32'h11;
        bus.memwb_we_in   = 1'b1;
        bus.memwb_rd_in   = 5'd3;
        bus.memwb_data_in = 32'h22;
        step();
        check_val("s2_exmem_prio", 64'(bus.ALUop1_out), 64'h11);

        // 2b: MEM/WB used when EX/MEM targets another register
        bus.rs1_addr_in = 5'd6;
        bus.memwb_rd_in = 5'd6;
        step();
        check_val("s2_memwb", 64'(bus.ALUop1_out), 64'h22);

        // 2c: write-enable low means no forwarding
        bus.rs1_addr_in = 5'd3;
        bus.exmem_we_in = 1'b0;
        bus.memwb_we_in = 1'b0;
        step();
        check_val("s2_no_we", 64'(bus.ALUop1_out), 64'h99);

        // 2d: x0 forced to zero despite a writer claiming rd=0
        bus.rs2_addr_in   = 5'd0;
        bus.rs2_data_in   = 32'h55;
        bus.exmem_we_in   = 1'b1;
        bus.exmem_rd_in   = 5'd0;
        bus.exmem_data_in = 32'hFF;
        step();
        check_val("s2_x0_op2",   64'(bus.ALUop2_out), 64'd0);
        check_val("s2_x0_store", 64'(bus.store_data_out), 64'd0);

        // 3: immediate operand, store data still forwarded rs2
        idle_inputs();
        bus.valid_in      = 1'b1;
        bus.ALUsrc_in     = 1'b1;
        bus.imm_in        = 32'hFFFFF800;
        bus.ALUctrl_in    = 3'b101;
        bus.rs2_addr_in   = 5'd9;
        bus.rs2_data_in   = 32'h1;
        bus.memwb_we_in   = 1'b1;
        bus.memwb_rd_in   = 5'd9;
        bus.memwb_data_in = 32'h44;
        bus.rd_addr_in    = 5'd12;
        bus.regwrite_in   = 1'b1;
        step();
        check_val("s3_op2",   64'(bus.ALUop2_out), 64'hFFFFF800);
        check_val("s3_store", 64'(bus.store_data_out), 64'h44);
        check_val("s3_ctrl",  64'(bus.ALUctrl_out), 64'd5);

        // 4: backpressure for 4 cycles with a new instruction waiting
        bus.ready_in    = 1'b0;
        bus.imm_in      = 32'h12345678;
        bus.memwb_data_in = 32'h77;
        bus.ALUctrl_in  = 3'b010;
        #1;
        check_val("s4_ready_lo", 64'(bus.ready_out), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_val("s4_hold_op2",   64'(bus.ALUop2_out), 64'hFFFFF800);
            check_val("s4_hold_store", 64'(bus.store_data_out), 64'h44);
            check_val("s4_hold_ctrl",  64'(bus.ALUctrl_out), 64'd5);
            check_val("s4_hold_valid", 64'(bus.valid_out), 64'd1);
            check_val("s4_ready_out",  64'(bus.ready_out), 64'd0);
            check_val("s4_stall",      64'(bus.stall_cnt_out), 64'(i));
            check_val("s4_stall_sat",  64'(bus_s.stall_cnt_out), 64'((i > 3) ? 3 : i));
        end

        // Release: waiting instruction loads, counter keeps its value
        bus.ready_in = 1'b1;
        step();
        check_val("s4_rel_op2",   64'(bus.ALUop2_out), 64'h12345678);
        check_val("s4_rel_store", 64'(bus.store_data_out), 64'h77);
        check_val("s4_rel_stall", 64'(bus.stall_cnt_out), 64'd4);

        // Drain with no new request
        bus.valid_in = 1'b0;
        step();
        check_val("drain_valid", 64'(bus.valid_out), 64'd0);
        check_val("drain_rw",    64'(bus.regwrite_out), 64'd0);
        check_val("drain_ready", 64'(bus.ready_out), 64'd1);

        // 5: flush beats a simultaneous load
        drive_basic();
        step();
        check_val("s5_pre_valid", 64'(bus.valid_out), 64'd1);
        bus.flush_in = 1'b1;
        step();
        check_val("s5_flush_valid", 64'(bus.valid_out), 64'd0);
        check_val("s5_flush_rw",    64'(bus.regwrite_out), 64'd0);

        // Flush during backpressure: cleared and not counted as a stall
        bus.flush_in = 1'b0;
        step();
        bus.ready_in = 1'b0;
        bus.flush_in = 1'b1;
        step();
        check_val("s5_hflush_valid", 64'(bus.valid_out), 64'd0);
        check_val("s5_hflush_stall", 64'(bus.stall_cnt_out), 64'd4);

        // 6: asynchronous reset in the middle of a hold
        drive_basic();
        step();
        bus.ready_in = 1'b0;
        step();
        check_val("s6_pre_stall",  64'(bus.stall_cnt_out), 64'd5);
        check_val("s6_pre_valid",  64'(bus.valid_out), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("s6_rst_valid", 64'(bus.valid_out), 64'd0);
        check_val("s6_rst_op1",   64'(bus.ALUop1_out), 64'd0);
        check_val("s6_rst_op2",   64'(bus.ALUop2_out), 64'd0);
        check_val("s6_rst_store", 64'(bus.store_data_out), 64'd0);
        check_val("s6_rst_pc",    64'(bus.pc_out), 64'd0);
        check_val("s6_rst_rd",    64'(bus.rd_addr_out), 64'd0);
        check_val("s6_rst_stall", 64'(bus.stall_cnt_out), 64'd0);
        check_val("s6_rst_ssat",  64'(bus_s.stall_cnt_out), 64'd0);
        step();
        check_val("s6_rst_hold", 64'(bus.valid_out), 64'd0);
        rst_n = 1'b1;
        drive_basic();
        step();
        check_basic("s6_post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
